// File: rtl/sr_flag_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sr_flag_arbiter
// Description : Round-robin arbiter serialising set/clear requests onto a
//               shared flag register. Each grant applies one S or R operation
//               and returns the flag's prior value (test-and-set). A requester
//               may lock the arbiter for exclusive multi-operation access.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_flag_arbiter #(
   parameter int NREQ  = 4,
   parameter int NFLAG = 6,
   parameter int IDX_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       op,
   input  logic [NREQ*IDX_W-1:0] idx,
   input  logic [NREQ-1:0]       lock,
   output logic [NREQ-1:0]       gnt,
   output logic                  rdata,
   output logic                  err,
   output logic [NFLAG-1:0]      flags,
   output logic                  locked
);

   localparam int               PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PTR_W:0]   NREQ_C  = (PTR_W+1)'(NREQ);
   localparam logic [IDX_W:0]   NFLAG_C = (IDX_W+1)'(NFLAG);
   localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(NREQ-1);

   typedef enum logic [0:0] {
      ST_ARB = 1'b0,
      ST_ACK = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  owner_q, owner_d;
   logic              locked_q, locked_d;
   logic [NFLAG-1:0]  flags_q, flags_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [NREQ-1:0]   elig;
   logic              found;
   logic [PTR_W-1:0]  win;
   logic [PTR_W:0]    cand;
   logic [IDX_W-1:0]  win_idx;
   logic              win_op;
   logic              win_lock;
   logic              idx_ok;

   // Winner search: first eligible requester at or after ptr, wrapping; the
   // eligible set collapses to the owner while a lock is held.
   always_comb begin
      elig  = locked_q ? (req & (NREQ'(1) << owner_q)) : req;
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
         if (cand >= NREQ_C) begin
            cand = cand - NREQ_C;
         end
         if (!found && elig[cand[PTR_W-1:0]]) begin
            found = 1'b1;
            win   = cand[PTR_W-1:0];
         end
      end
      win_idx  = '0;
      win_op   = 1'b0;
      win_lock = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (win == PTR_W'(k)) begin
            win_idx  = idx[k*IDX_W +: IDX_W];
            win_op   = op[k];
            win_lock = lock[k];
         end
      end
      idx_ok = ({1'b0, win_idx} < NFLAG_C);
   end

   // Next-state: grant in ARB, then one mandatory ACK cycle so a held req is
   // never granted twice back to back.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      locked_d = locked_q;
      flags_d  = flags_q;
      gnt_d    = '0;
      rdata_d  = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         ST_ARB: begin
            if (found) begin
               gnt_d = NREQ'(1) << win;
               if (idx_ok) begin
                  rdata_d          = flags_q[win_idx];
                  flags_d[win_idx] = win_op;
               end else begin
                  err_d = 1'b1;
               end
               ptr_d = (win == LAST_C) ? '0 : win + 1'b1;
               // While locked the winner is always the owner, so a grant
               // without lock releases; a grant with lock (re)claims.
               locked_d = win_lock;
               if (win_lock) begin
                  owner_d = win;
               end
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_ARB;
         end
         default: begin
            state_d = ST_ARB;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_ARB;
         ptr_q    <= '0;
         owner_q  <= '0;
         locked_q <= 1'b0;
         flags_q  <= '0;
         gnt_q    <= '0;
         rdata_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         locked_q <= locked_d;
         flags_q  <= flags_d;
         gnt_q    <= gnt_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign gnt    = gnt_q;
   assign rdata  = rdata_q;
   assign err    = err_q;
   assign flags  = flags_q;
   assign locked = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_flag_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_flag_arbiter
// Description : Self-checking bench for sr_flag_arbiter. A behavioural model
//               tracks flags, pointer and lock and is compared every cycle;
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_flag_arbiter;

   localparam int NREQ  = 4;
   localparam int NFLAG = 6;
   localparam int IDX_W = 3;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ-1:0]       op = '0;
   logic [NREQ*IDX_W-1:0] idx = '0;
   logic [NREQ-1:0]       lock = '0;
   logic [NREQ-1:0]       gnt;
   logic                  rdata;
   logic                  err;
   logic [NFLAG-1:0]      flags;
   logic                  locked;

   int checks = 0;
   int errors = 0;

   sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx), .lock(lock),
      .gnt(gnt), .rdata(rdata), .err(err), .flags(flags), .locked(locked)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit              m_valid = 1'b0;
   bit              m_in_ack;
   bit              m_locked;
   int              m_ptr, m_owner, m_w, m_fi;
   bit              m_flags [NFLAG];
   logic [NREQ-1:0] e_gnt;
   logic            e_rdata, e_err;
   logic [NFLAG-1:0] e_fv;

   // Model update at each rising edge, then compare shortly after the edge.
   always @(posedge clk) begin
      if (rst) begin
         m_valid  = 1'b1;
         m_in_ack = 1'b0;
         m_locked = 1'b0;
         m_ptr    = 0;
         m_owner  = 0;
         for (int f = 0; f < NFLAG; f++) m_flags[f] = 1'b0;
         e_gnt = '0; e_rdata = 1'b0; e_err = 1'b0;
      end else if (m_in_ack) begin
         m_in_ack = 1'b0;
         e_gnt = '0; e_rdata = 1'b0; e_err = 1'b0;
      end else begin
         e_gnt = '0; e_rdata = 1'b0; e_err = 1'b0;
         m_w = -1;
         for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (m_w < 0 && req[c] && (!m_locked || c == m_owner)) m_w = c;
         end
         if (m_w >= 0) begin
            m_fi  = int'(idx[m_w*IDX_W +: IDX_W]);
            e_gnt = NREQ'(1) << m_w;
            if (m_fi < NFLAG) begin
               e_rdata        = m_flags[m_fi];
               m_flags[m_fi]  = op[m_w];
            end else begin
               e_err = 1'b1;
            end
            m_ptr = (m_w + 1) % NREQ;
            if (lock[m_w]) begin
               m_locked = 1'b1;
               m_owner  = m_w;
            end else begin
               m_locked = 1'b0;
            end
            m_in_ack = 1'b1;
         end
      end
      #1;
      if (m_valid) begin
         for (int f = 0; f < NFLAG; f++) e_fv[f] = m_flags[f];
         checks++;
         if ({gnt, rdata, err, flags, locked} !== {e_gnt, e_rdata, e_err, e_fv, m_locked}) begin
            errors++;
            $display("FAIL model_cmp t=%0t: gnt=%b rdata=%b err=%b flags=%b locked=%b required gnt=%b rdata=%b err=%b flags=%b locked=%b",
                     $time, gnt, rdata, err, flags, locked, e_gnt, e_rdata, e_err, e_fv, m_locked);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic int oh2i(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic set_req(input int k, input bit r, input bit o, input int ix, input bit lk);
      req[k]                  = r;
      op[k]                   = o;
      idx[k*IDX_W +: IDX_W]   = IDX_W'(ix);
      lock[k]                 = lk;
   endtask

   // Raise one request, wait (bounded) for its grant, capture outputs, drop it.
   task automatic do_req(input int k, input bit o, input int ix, input bit lk,
                         output logic [NREQ-1:0] g, output logic rd, output logic er);
      int n;
      g = '0; rd = 1'b0; er = 1'b0;
      set_req(k, 1'b1, o, ix, lk);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (gnt == '0 && n < 12);
      if (gnt == '0) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout: requester %0d got no grant, required one within 12 cycles", k);
      end else begin
         g = gnt; rd = rdata; er = err;
      end
      req[k]  = 1'b0;
      lock[k] = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   logic [NREQ-1:0]  g;
   logic             rd, er;
   logic [NFLAG-1:0] fl_before;
   int               order[$];
   int               lk_after[$];
   int               consec, n, c2, w;
   logic [NREQ-1:0]  prev_g;
   int               exp_rr[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
   int               exp_lk[8]   = '{0, 1, 2, 2, 2, 2, 2, 3};
   int               exp_lkd[8]  = '{0, 0, 1, 1, 1, 1, 0, 0};

   initial begin
      // Reset and single set
      repeat (2) @(negedge clk);
      chk("reset_gnt", 32'(gnt), 32'h0);
      chk("reset_flags", 32'(flags), 32'h0);
      chk("reset_locked", 32'(locked), 32'h0);
      chk("reset_rdata_err", 32'({rdata, err}), 32'h0);
      rst = 1'b0;
      do_req(1, 1'b1, 2, 1'b0, g, rd, er);
      chk("set1_gnt", 32'(g), 32'b0010);
      chk("set1_rdata", 32'(rd), 32'h0);
      chk("set1_flags", 32'(flags), 32'b000100);

      // Test-and-set then clear
      do_req(1, 1'b1, 2, 1'b0, g, rd, er);
      chk("tas_rdata", 32'(rd), 32'h1);
      chk("tas_flags", 32'(flags), 32'b000100);
      do_req(3, 1'b0, 2, 1'b0, g, rd, er);
      chk("clr_gnt", 32'(g), 32'b1000);
      chk("clr_rdata", 32'(rd), 32'h1);
      chk("clr_flags", 32'(flags), 32'h0);

      // Round-robin with all four requesting for 16 cycles
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 1'b1, k, 1'b0);
      order.delete();
      consec = 0;
      prev_g = '0;
      repeat (16) begin
         @(negedge clk);
         if (gnt != '0) order.push_back(oh2i(gnt));
         if (gnt != '0 && prev_g != '0) consec++;
         prev_g = gnt;
      end
      req = '0;
      chk("rr_count", 32'(order.size()), 32'd8);
      chk("rr_back_to_back", 32'(consec), 32'd0);
      for (int i = 0; i < 8 && i < order.size(); i++)
         chk($sformatf("rr_order[%0d]", i), 32'(order[i]), 32'(exp_rr[i]));
      chk("rr_flags", 32'(flags), 32'b001111);

      // Lock: requester 2 locks, keeps 4 grants, then releases
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 1'b0, k, k == 2);
      order.delete();
      lk_after.delete();
      n = 0; c2 = 0;
      while (order.size() < 8 && n < 60) begin
         @(negedge clk);
         n++;
         if (gnt != '0) begin
            w = oh2i(gnt);
            order.push_back(w);
            lk_after.push_back(int'(locked));
            if (w == 2) c2++;
            if (c2 == 4) lock[2] = 1'b0;
         end
      end
      req = '0; lock = '0;
      chk("lock_count", 32'(order.size()), 32'd8);
      for (int i = 0; i < 8 && i < order.size(); i++) begin
         chk($sformatf("lock_order[%0d]", i), 32'(order[i]), 32'(exp_lk[i]));
         chk($sformatf("lock_state[%0d]", i), 32'(lk_after[i]), 32'(exp_lkd[i]));
      end

      // Illegal index: grant consumed, err set, flags untouched, ptr advanced
      @(negedge clk);
      fl_before = flags;
      do_req(0, 1'b1, 7, 1'b0, g, rd, er);
      chk("ill_gnt", 32'(g), 32'b0001);
      chk("ill_err", 32'(er), 32'h1);
      chk("ill_flags", 32'(flags), 32'(fl_before));
      @(negedge clk);
      set_req(0, 1'b1, 1'b1, 4, 1'b0);
      set_req(1, 1'b1, 1'b1, 5, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (gnt == '0 && n < 12);
      chk("ill_next_winner", 32'(gnt), 32'b0010);
      req = '0;

      // Reset mid-operation during the ACK of a locked grant
      for (int b = 0; b < NFLAG; b++) do_req(0, (b % 2) == 1, b, 1'b0, g, rd, er);
      chk("pre_rst_flags", 32'(flags), 32'b101010);
      do_req(2, 1'b1, 1, 1'b1, g, rd, er);
      chk("pre_rst_locked", 32'(locked), 32'h1);
      chk("pre_rst_gnt", 32'(g), 32'b0100);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_flags", 32'(flags), 32'h0);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      rst = 1'b0;
      for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 1'b1, k, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (gnt == '0 && n < 12);
      chk("post_rst_winner", 32'(gnt), 32'b0001);
      req = '0;
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sr_flag_arbiter.md
# sr_flag_arbiter

Round-robin arbiter that shares a bank of set/reset flag bits among several requesters. Each requester asks to set or clear one flag. The block serialises the requests, applies exactly one S or R operation per grant to its internal SR flag register, and returns the flag's prior value so the requester gets test-and-set semantics. An optional lock lets one requester keep exclusive access across several operations. It sits between requester FSMs and the shared flag state that the SR flip-flop bank used to hold directly.

## Interface
- NREQ, 4: number of requesters (2..8)
- NFLAG, 6: number of flag bits
- IDX_W, 3: flag index width; indices >= NFLAG are illegal
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester request, held high until gnt is seen
- op  in  NREQ  per-requester operation: 1 = set (S), 0 = clear (R)
- idx  in  NREQ*IDX_W  per-requester flag index; requester k uses bits [k*IDX_W +: IDX_W]
- lock  in  NREQ  per-requester lock request, sampled with req
- gnt  out  NREQ  one-hot grant, high for exactly one cycle
- rdata  out  1  flag value before the granted operation; valid only while gnt is nonzero
- err  out  1  pulses with gnt when the granted idx >= NFLAG
- flags  out  NFLAG  current flag register
- locked  out  1  high while a lock owner holds exclusive access

## Operation
- The FSM has two states, ARB and ACK. Reset enters ARB.
- **ARB:** the eligible set is req, masked to the lock owner only while locked. If the eligible set is empty, stay in ARB with gnt = 0. Otherwise:
  - Pick winner w: the first eligible index searching upward from ptr and wrapping NREQ-1 -> 0.
  - Register gnt = onehot(w), rdata = flags[idx_w], and err = (idx_w >= NFLAG).
  - If idx_w is legal, update flags[idx_w] to op_w: set gives 1, clear gives 0. Set or clear of an already set or cleared bit is legal and leaves the bit unchanged.
  - Update ptr = (w+1) mod NREQ. Go to ACK.
- **ACK:** gnt is high this cycle and no new arbitration happens, so a requester that is still holding req is not double-granted. Go to ARB.
- **Lock:**
  - If lock_w = 1 at the winning ARB cycle, the block enters or stays in locked mode with owner = w.
  - If lock_w = 0 at a grant to the owner, locked mode is released.
  - While locked, other requesters are masked and the owner's req may stay low indefinitely (no timeout).
- An illegal idx leaves flags unchanged. It still consumes the grant, advances ptr and applies the lock rule.
- Only one flag changes per grant. S and R are never applied to the same bit simultaneously, so the SR invalid state cannot occur.

## Timing
- **Reset:** flags = 0, gnt = 0, rdata = 0, err = 0, locked = 0, ptr = 0, owner = 0, state = ARB.
  - Reset applies at the first rising edge with rst = 1 and overrides any in-flight grant or lock.
- **Latency:**
  - A req sampled high at an ARB edge t produces gnt, rdata, err and the updated flags visible at cycle t+1.
  - The earliest next grant is at cycle t+3 (ACK at t+1, ARB edge at t+2).
- **Throughput:** at most one grant per 2 cycles.
- **Handshake:**
  - A requester drops req, or changes op/idx for its next request, in the cycle after it sees gnt.
  - A req still high at the next ARB edge counts as a new request.
- **Sampling:** op, idx and lock are sampled only at the ARB edge that grants the requester. Changes while not granted are ignored.
- **Priority wrap:** with ptr = NREQ-1 and requesters 0 and NREQ-1 both requesting, NREQ-1 wins and ptr wraps to 0.
- **Fairness:** with all requesters continuously requesting and no lock, grants rotate 0,1,...,NREQ-1,0,...
- rdata and err are 0 whenever gnt = 0.

## Test plan
- **Reset and single set:** rst for 2 cycles, then req[1] = 1, op = 1, idx = 2.
  - Required: gnt = 4'b0010 one cycle after sampling, rdata = 0, flags = 6'b000100.
- **Test-and-set then clear:** repeat set of flag 2 by requester 1 -> rdata = 1 and flags unchanged. Then requester 3 clears flag 2 -> rdata = 1, flags = 0.
- **Round-robin:** req = 4'b1111 held for 16 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3, each on alternate cycles, never two consecutive gnt cycles.
- **Lock:** requester 2 wins with lock = 1 while req = 4'b1111.
  - Required: the next three grants all go to 2 and locked = 1.
  - Then requester 2 is granted with lock = 0 -> locked = 0, and the next grant goes to 3.
- **Illegal index:** requester 0 with idx = 7 (NFLAG = 6).
  - Required: gnt[0] with err = 1, flags unchanged, ptr advanced so requester 1 wins next when both 0 and 1 request.
- **Reset mid-operation:** assert rst in the ACK cycle of a locked grant with flags = 6'b101010.
  - Required: next cycle flags = 0, gnt = 0, locked = 0, and the first subsequent grant goes to requester 0 when all request.
